// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // One staged register-file write: enable, destination select, data.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wsel;
    logic [DATA_W-1:0] wdat;
  } rf_wreq_t;

  // Register 0 is hard-wired; writes to it are dropped.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   cand;

  // Scan N candidate slots starting at ptr; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        gnt_o[cand[IDX_W-1:0]]   = 1'b1;
        idx_o                    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between NREQ writeback
// requesters. Round-robin grant, one output stage register, and a
// same-cycle bypass of the staged write for two read selects.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = rf_arb_pkg::ADDR_W,
  parameter int DATA_W = rf_arb_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_wsel,
  input  logic [NREQ*DATA_W-1:0] req_wdat,
  output logic                   rf_WEN,
  output logic [ADDR_W-1:0]      rf_wsel,
  output logic [DATA_W-1:0]      rf_wdat,
  input  logic [ADDR_W-1:0]      byp_rsel1,
  input  logic [ADDR_W-1:0]      byp_rsel2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [DATA_W-1:0]      byp_dat
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(REG_ZERO);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              stage_vld_q, stage_vld_d;
  logic [ADDR_W-1:0] stage_wsel_q, stage_wsel_d;
  logic [DATA_W-1:0] stage_wdat_q, stage_wdat_d;

  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gidx;
  logic              grant;
  logic [ADDR_W-1:0] sel_wsel;
  logic [DATA_W-1:0] sel_wdat;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (PTR_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // Ready is forced low while reset is held so no handshake can be seen
  // as completing against a stage that is being cleared.
  assign req_ready = rst ? '0 : gnt;
  assign grant     = |gnt;
  assign sel_wsel  = req_wsel[gidx*ADDR_W +: ADDR_W];
  assign sel_wdat  = req_wdat[gidx*DATA_W +: DATA_W];

  // Next stage contents and pointer: load the granted write, else drop enable and hold.
  always_comb begin
    stage_vld_d  = 1'b0;
    stage_wsel_d = stage_wsel_q;
    stage_wdat_d = stage_wdat_q;
    ptr_d        = ptr_q;
    if (grant) begin
      stage_wsel_d = sel_wsel;
      stage_wdat_d = sel_wdat;
      stage_vld_d  = (sel_wsel != ZERO_SEL);
      ptr_d        = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Stage register and round-robin pointer, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld_q  <= 1'b0;
      stage_wsel_q <= '0;
      stage_wdat_q <= '0;
      ptr_q        <= '0;
    end else begin
      stage_vld_q  <= stage_vld_d;
      stage_wsel_q <= stage_wsel_d;
      stage_wdat_q <= stage_wdat_d;
      ptr_q        <= ptr_d;
    end
  end

  assign rf_WEN  = stage_vld_q;
  assign rf_wsel = stage_wsel_q;
  assign rf_wdat = stage_wdat_q;

  // Bypass: the staged write lands on the next edge, so readers of the
  // same register take it from here. Register 0 never hits.
  assign byp_hit1 = stage_vld_q && (byp_rsel1 == stage_wsel_q) && (byp_rsel1 != ZERO_SEL);
  assign byp_hit2 = stage_vld_q && (byp_rsel2 == stage_wsel_q) && (byp_rsel2 != ZERO_SEL);
  assign byp_dat  = stage_wdat_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (NREQ=3, ADDR_W=5, DATA_W=32).
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_wsel;
  logic [95:0] req_wdat;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  byp_rsel1, byp_rsel2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_dat;

  int n_vec = 0;
  int n_err = 0;

  rf_wreq_t sbq[$];
  rf_wreq_t m_stage;

  typedef struct packed {
    logic [2:0]  valid;
    logic [14:0] wsel;
    logic [95:0] wdat;
    logic [2:0]  exp_ready;
  } vec_t;

  vec_t vecs[15];

  rf_write_arbiter #(.NREQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wsel  (req_wsel),
    .req_wdat  (req_wdat),
    .rf_WEN    (rf_WEN),
    .rf_wsel   (rf_wsel),
    .rf_wdat   (rf_wdat),
    .byp_rsel1 (byp_rsel1),
    .byp_rsel2 (byp_rsel2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_dat   (byp_dat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] r);
    vec_t t;
    t.valid     = v;
    t.wsel      = {s2, s1, s0};
    t.wdat      = {d2, d1, d0};
    t.exp_ready = r;
    return t;
  endfunction

  // Drive one vector, check ready, push the expected stage, then check the stage after the edge.
  task automatic step(input vec_t v);
    rf_wreq_t e;
    int g;
    @(negedge clk);
    req_valid = v.valid;
    req_wsel  = v.wsel;
    req_wdat  = v.wdat;
    #1;
    check("req_ready", 64'(req_ready), 64'(v.exp_ready));
    g = -1;
    for (int i = 0; i < 3; i++) if (v.exp_ready[i]) g = i;
    if (g >= 0) begin
      e.wsel  = v.wsel[g*5 +: 5];
      e.wdat  = v.wdat[g*32 +: 32];
      e.valid = (e.wsel != 5'd0);
    end else begin
      e       = m_stage;
      e.valid = 1'b0;
    end
    m_stage = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("rf_WEN",  64'(rf_WEN),  64'(e.valid));
    check("rf_wsel", 64'(rf_wsel), 64'(e.wsel));
    check("rf_wdat", 64'(rf_wdat), 64'(e.wdat));
    byp_rsel1 = e.wsel;
    byp_rsel2 = e.wsel ^ 5'd1;
    #1;
    check("byp_hit1", 64'(byp_hit1), 64'(e.valid));
    check("byp_hit2", 64'(byp_hit2), 64'd0);
    check("byp_dat",  64'(byp_dat),  64'(e.wdat));
  endtask

  initial begin
    // Vector table: ptr starts at 0 after reset.
    vecs[0]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        3'b000);
    vecs[1]  = mk(3'b111, 5'd1,  5'd2,  5'd3,  32'h10000001, 32'h10000002, 32'h10000003, 3'b001);
    vecs[2]  = mk(3'b111, 5'd4,  5'd5,  5'd6,  32'h20000001, 32'h20000002, 32'h20000003, 3'b010);
    vecs[3]  = mk(3'b111, 5'd7,  5'd8,  5'd9,  32'h30000001, 32'h30000002, 32'h30000003, 3'b100);
    vecs[4]  = mk(3'b111, 5'd10, 5'd11, 5'd12, 32'h40000001, 32'h40000002, 32'h40000003, 3'b001);
    vecs[5]  = mk(3'b111, 5'd13, 5'd14, 5'd15, 32'h50000001, 32'h50000002, 32'h50000003, 3'b010);
    vecs[6]  = mk(3'b111, 5'd16, 5'd17, 5'd18, 32'h60000001, 32'h60000002, 32'h60000003, 3'b100);
    vecs[7]  = mk(3'b010, 5'd0,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        3'b010);
    vecs[8]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        3'b000);
    vecs[9]  = mk(3'b100, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h00001234, 3'b100);
    vecs[10] = mk(3'b110, 5'd0,  5'd20, 5'd21, 32'h0,        32'h70000002, 32'h70000003, 3'b010);
    vecs[11] = mk(3'b011, 5'd22, 5'd23, 5'd0,  32'h80000001, 32'h80000002, 32'h0,        3'b001);
    vecs[12] = mk(3'b101, 5'd24, 5'd0,  5'd25, 32'h90000001, 32'h0,        32'h90000003, 3'b100);
    vecs[13] = mk(3'b001, 5'd9,  5'd0,  5'd0,  32'hA0000001, 32'h0,        32'h0,        3'b001);
    vecs[14] = mk(3'b111, 5'd26, 5'd9,  5'd27, 32'hB0000001, 32'hB0000002, 32'hB0000003, 3'b010);

    rst = 1'b1;
    req_valid = '0; req_wsel = '0; req_wdat = '0;
    byp_rsel1 = '0; byp_rsel2 = '0;
    m_stage = '0;
    #12;
    check("reset rf_WEN",  64'(rf_WEN),  64'd0);
    check("reset rf_wsel", 64'(rf_wsel), 64'd0);
    check("reset rf_wdat", 64'(rf_wdat), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) step(vecs[i]);

    // Bypass on a staged wsel=7 write; ptr is 2 here, so requester 1 is reached after wrap.
    step(mk(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hA5A5A5A5, 32'h0, 3'b010));
    byp_rsel1 = 5'd7;
    byp_rsel2 = 5'd8;
    #1;
    check("bypass hit1", 64'(byp_hit1), 64'd1);
    check("bypass hit2", 64'(byp_hit2), 64'd0);
    check("bypass dat",  64'(byp_dat),  64'hA5A5A5A5);
    step(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000));

    // Mid-cycle asynchronous reset with all requesters valid (ptr is 2 before it).
    @(negedge clk);
    req_valid = 3'b111;
    req_wsel  = {5'd3, 5'd2, 5'd1};
    req_wdat  = {32'hC3, 32'hC2, 32'hC1};
    #1;
    rst = 1'b1;
    #1;
    check("async rst rf_WEN",    64'(rf_WEN),    64'd0);
    check("async rst rf_wsel",   64'(rf_wsel),   64'd0);
    check("async rst rf_wdat",   64'(rf_wdat),   64'd0);
    check("async rst req_ready", 64'(req_ready), 64'd0);
    sbq.delete();
    m_stage = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    step(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hD1, 32'hD2, 32'hD3, 3'b001));

    // Reset between handshake and edge: the wsel=3 write must never appear.
    @(negedge clk);
    req_valid = 3'b001;
    req_wsel  = {5'd0, 5'd0, 5'd3};
    req_wdat  = {32'h0, 32'h0, 32'hE3};
    #1;
    check("pre-rst ready", 64'(req_ready), 64'b001);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("held rst rf_WEN",  64'(rf_WEN),  64'd0);
    check("held rst rf_wsel", 64'(rf_wsel), 64'd0);
    sbq.delete();
    m_stage = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    step(mk(3'b111, 5'd4, 5'd5, 5'd6, 32'hF1, 32'hF2, 32'hF3, 3'b001));
    step(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
